// File: rtl/alu2_rep_pipe_if.sv
// Handshake and operand bundle between decode/operand-read, the ALU2 pipe and the memory-address stage.
interface alu2_rep_pipe_if #(
  parameter int DW = 32,
  parameter int CW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu2_op;
  logic [1:0]    op_size;
  logic          in_rep;
  logic          DF_in;
  logic [DW-1:0] sr1;
  logic [DW-1:0] sr2;
  logic [DW-1:0] esp;
  logic [DW-1:0] eip_next;
  logic [CW-1:0] rep_cnt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_res2;
  logic [CW-1:0] out_cnt;
  logic          out_last;
  logic          out_skip;
  logic          out_err;

  modport master (
    output in_valid, alu2_op, op_size, in_rep, DF_in, sr1, sr2, esp, eip_next, rep_cnt, out_ready,
    input  in_ready, out_valid, alu_res2, out_cnt, out_last, out_skip, out_err
  );

  modport slave (
    input  in_valid, alu2_op, op_size, in_rep, DF_in, sr1, sr2, esp, eip_next, rep_cnt, out_ready,
    output in_ready, out_valid, alu_res2, out_cnt, out_last, out_skip, out_err
  );
endinterface

// File: rtl/alu2_rep_pipe.sv
// Pipelined ALU2 secondary-result unit: pointer/stack/EIP result with a registered
// valid/ready output and a REP sequencer that expands one string op into N beats.
//
// state  | meaning
// S_IDLE | accepting ops; output register holds at most one non-sequenced result
// S_REP  | issuing string-step beats from the latched pointer, upstream stalled
module alu2_rep_pipe #(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input logic           clk,
  input logic           rst,
  alu2_rep_pipe_if.slave bus
);
  typedef enum logic [0:0] {S_IDLE, S_REP} state_t;

  state_t        state_q;
  logic          valid_q;
  logic [DW-1:0] res_q;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          skip_q;
  logic          err_q;
  logic [DW-1:0] step_q;
  logic          df_q;

  logic [DW-1:0] step_d;
  logic          size_bad;
  logic [DW-1:0] res_d;
  logic          err_d;
  logic          is_str;
  logic          rep_go;
  logic          rep_skip;
  logic          accept;
  logic          out_fire;
  logic [DW-1:0] ptr_d;

  assign bus.in_ready  = (state_q == S_IDLE) && (!valid_q || bus.out_ready);
  assign bus.out_valid = valid_q;
  assign bus.alu_res2  = res_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_last  = last_q;
  assign bus.out_skip  = skip_q;
  assign bus.out_err   = err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = valid_q && bus.out_ready;

  always_comb begin
    step_d   = '0;
    size_bad = 1'b0;
    case (bus.op_size)
      2'b00:   step_d = DW'(1);
      2'b01:   step_d = DW'(2);
      2'b10:   step_d = DW'(4);
      default: size_bad = 1'b1;
    endcase
  end

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (bus.alu2_op)
      4'b0000: res_d = bus.sr1;
      4'b0001: res_d = bus.sr2;
      4'b0010: res_d = bus.eip_next;
      4'b0100: res_d = bus.esp + step_d;
      4'b0110: res_d = bus.esp - step_d;
      4'b1000: res_d = bus.esp + step_d + bus.sr2;
      4'b0101: res_d = bus.DF_in ? (bus.sr2 - step_d) : (bus.sr2 + step_d);
      default: err_d = 1'b1;
    endcase
    // A reserved size poisons every op, including REP, into a single error beat.
    if (size_bad) begin
      res_d = '0;
      err_d = 1'b1;
    end
  end

  assign is_str   = (bus.alu2_op == 4'b0101) && bus.in_rep && !err_d;
  assign rep_go   = is_str && (bus.rep_cnt != '0);
  assign rep_skip = is_str && (bus.rep_cnt == '0);
  assign ptr_d    = df_q ? (res_q - step_q) : (res_q + step_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      df_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            valid_q <= 1'b1;
            err_q   <= err_d;
            skip_q  <= rep_skip;
            if (rep_go) begin
              state_q <= S_REP;
              res_q   <= res_d;
              cnt_q   <= bus.rep_cnt - CW'(1);
              last_q  <= (bus.rep_cnt == CW'(1));
              step_q  <= step_d;
              df_q    <= bus.DF_in;
            end else begin
              res_q  <= rep_skip ? bus.sr2 : res_d;
              cnt_q  <= '0;
              last_q <= 1'b1;
            end
          end else if (out_fire) begin
            valid_q <= 1'b0;
          end
        end
        S_REP: begin
          if (out_fire) begin
            if (last_q) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end else begin
              res_q  <= ptr_d;
              cnt_q  <= cnt_q - CW'(1);
              last_q <= (cnt_q == CW'(1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
